// File: rtl/io_port_arbiter.sv
// rtl/io_port_arbiter.sv - two-requester arbiter for the shared I/O data memory port
// Optional build macro: IO_ARB_ROUND_ROBIN_EN (alternate ties instead of fixed priority to requester 0)
module io_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  wren0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  wren1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Counter covers READ_LATENCY up to 4, so it never needs more than two bits.
  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  state_t     state;
  logic [1:0] cnt;
  logic       txn_wr;
  logic       win;

`ifdef IO_ARB_ROUND_ROBIN_EN
  logic       last_grant;

  // Winner selection: on a tie the requester that did not win last time goes first.
  always_comb begin
    win = req1;
    if (req0 && req1) win = ~last_grant;
  end
`else
  // Winner selection: requester 0 always wins a tie.
  always_comb begin
    win = ~req0;
  end
`endif

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      txn_wr    <= 1'b0;
      busy      <= 1'b0;
      grant_id  <= 1'b0;
      mem_addr  <= '0;
      mem_wren  <= 1'b0;
      mem_wdata <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
`ifdef IO_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          mem_wren <= 1'b0;
          if (req0 || req1) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            grant_id  <= win;
            mem_addr  <= win ? addr1 : addr0;
            mem_wdata <= win ? wdata1 : wdata0;
            mem_wren  <= win ? wren1 : wren0;
            txn_wr    <= win ? wren1 : wren0;
`ifdef IO_ARB_ROUND_ROBIN_EN
            last_grant <= win;
`endif
          end
        end
        ISSUE: begin
          state    <= WAIT;
          mem_wren <= 1'b0;
          cnt      <= CNT_INIT;
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            state <= DONE;
            if (!txn_wr) begin
              if (grant_id) rdata1 <= mem_rdata;
              else          rdata0 <= mem_rdata;
            end
            if (grant_id) ack1 <= 1'b1;
            else          ack0 <= 1'b1;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_arbiter.sv
// tb/tb_io_port_arbiter.sv - scoreboard bench for io_port_arbiter (instance 0: RL=1, instance 1: RL=3)
module tb_io_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0 [2];
  logic        wren0 [2];
  logic [31:0] addr0 [2];
  logic [31:0] wdata0 [2];
  logic        ack0 [2];
  logic [31:0] rdata0 [2];
  logic        req1 [2];
  logic        wren1 [2];
  logic [31:0] addr1 [2];
  logic [31:0] wdata1 [2];
  logic        ack1 [2];
  logic [31:0] rdata1 [2];
  logic [31:0] mem_addr [2];
  logic        mem_wren [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy [2];
  logic        grant_id [2];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int RL = (g == 0) ? 1 : 3;
    localparam logic [31:0] BASE = (g == 0) ? 32'hA000_0000 : 32'hB000_0000;
    logic [31:0] mem [64];
    logic [31:0] pipe [4];

    io_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(RL)) dut (
      .clk(clk), .rst(rst),
      .req0(req0[g]), .wren0(wren0[g]), .addr0(addr0[g]), .wdata0(wdata0[g]),
      .ack0(ack0[g]), .rdata0(rdata0[g]),
      .req1(req1[g]), .wren1(wren1[g]), .addr1(addr1[g]), .wdata1(wdata1[g]),
      .ack1(ack1[g]), .rdata1(rdata1[g]),
      .mem_addr(mem_addr[g]), .mem_wren(mem_wren[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g]), .grant_id(grant_id[g])
    );

    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 64; i++) mem[i] <= BASE | 32'(i);
      end else if (mem_wren[g]) begin
        mem[mem_addr[g][7:2]] <= mem_wdata[g];
      end
      pipe[0] <= mem[mem_addr[g][7:2]];
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata[g] = pipe[RL-1];
  end

  typedef struct {
    int          inst;
    bit          id;
    logic [31:0] rd;
    bit          chk_rd;
    int          cyc;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack pops the oldest expectation and is compared against it.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ack0[i] || ack1[i]) begin
        chk("ack_onehot", 64'(ack0[i] & ack1[i]), 64'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack inst=%0d ack0=%0b ack1=%0b required=no_ack", i, ack0[i], ack1[i]);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_inst", 64'(i), 64'(mon_e.inst));
          chk("ack_id", 64'(ack1[i]), 64'(mon_e.id));
          chk("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
          if (mon_e.chk_rd)
            chk("ack_rdata", 64'(mon_e.id ? rdata1[i] : rdata0[i]), 64'(mon_e.rd));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input bit id, input bit wr, input logic [31:0] rd, input int c);
    exp_t e;
    e.inst = i; e.id = id; e.rd = rd; e.chk_rd = !wr; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic start(input int i, input bit id, input bit wr, input logic [31:0] a, input logic [31:0] d);
    if (id) begin
      req1[i] = 1'b1; wren1[i] = wr; addr1[i] = a; wdata1[i] = d;
    end else begin
      req0[i] = 1'b1; wren0[i] = wr; addr0[i] = a; wdata0[i] = d;
    end
  endtask

  task automatic wait_ack(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ack0[i] || ack1[i]) && n < 50);
    if (!(ack0[i] || ack1[i])) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout inst=%0d actual=no_ack required=ack within 50 cycles", i);
    end
  endtask

  bit tie_ids [4];
  int c;

  initial begin
`ifdef IO_ARB_ROUND_ROBIN_EN
    tie_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    tie_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 2; i++) begin
      req0[i] = 0; wren0[i] = 0; addr0[i] = 0; wdata0[i] = 0;
      req1[i] = 0; wren1[i] = 0; addr1[i] = 0; wdata1[i] = 0;
    end

    // Reset held for two cycles: everything reads back zero.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ctrl", 64'({ack0[i], ack1[i], mem_wren[i], busy[i], grant_id[i]}), 64'd0);
      chk("rst_rdata0", 64'(rdata0[i]), 64'd0);
      chk("rst_rdata1", 64'(rdata1[i]), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr[i]), 64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata[i]), 64'd0);
    end
    step();
    rst = 1'b0;
    step();

    // Single write from requester 1.
    c = cyc;
    start(0, 1, 1, 32'h1000_0040, 32'hDEAD_BEEF);
    push(0, 1, 1, 32'h0, c + 3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wr_mem_wren", 64'(mem_wren[0]), 64'(k == 1));
      if (k == 1) begin
        chk("wr_mem_addr", 64'(mem_addr[0]), 64'h1000_0040);
        chk("wr_mem_wdata", 64'(mem_wdata[0]), 64'hDEAD_BEEF);
        chk("wr_busy", 64'(busy[0]), 64'd1);
      end
    end
    step();
    req1[0] = 0; wren1[0] = 0;

    // Read back from requester 0; requester 1 read data must not move.
    c = cyc;
    start(0, 0, 0, 32'h1000_0040, 32'h0);
    push(0, 0, 0, 32'hDEAD_BEEF, c + 3);
    wait_ack(0);
    step();
    req0[0] = 0;
    chk("rd_rdata1_held", 64'(rdata1[0]), 64'd0);

    // Fresh reset, then a single tie: requester 0 first, requester 1 four cycles later.
    rst = 1'b1;
    step();
    rst = 1'b0;
    c = cyc;
    start(0, 0, 0, 32'h0000_0004, 32'h0);
    start(0, 1, 0, 32'h0000_0008, 32'h0);
    push(0, 0, 0, 32'hA000_0001, c + 3);
    push(0, 1, 0, 32'hA000_0002, c + 7);
    wait_ack(0);
    step();
    req0[0] = 0;
    wait_ack(0);
    step();
    req1[0] = 0;

    // Both requests held for four transactions.
    c = cyc;
    start(0, 0, 0, 32'h0000_000C, 32'h0);
    start(0, 1, 0, 32'h0000_0010, 32'h0);
    for (int k = 0; k < 4; k++)
      push(0, tie_ids[k], 0, tie_ids[k] ? 32'hA000_0004 : 32'hA000_0003, c + 3 + 4 * k);
    for (int k = 0; k < 4; k++) wait_ack(0);
    step();
    req0[0] = 0; req1[0] = 0;

    // Reset during WAIT of a read: no ack, outputs cleared, then a clean retry.
    c = cyc;
    start(0, 0, 0, 32'h0000_0014, 32'h0);
    step();
    step();
    rst = 1'b1;
    req0[0] = 0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy[0]), 64'd0);
    chk("abort_ack0", 64'(ack0[0]), 64'd0);
    chk("abort_rdata0", 64'(rdata0[0]), 64'd0);
    repeat (4) step();
    c = cyc;
    start(0, 0, 0, 32'h0000_0014, 32'h0);
    push(0, 0, 0, 32'hA000_0005, c + 3);
    wait_ack(0);
    step();
    req0[0] = 0;

    // READ_LATENCY=3: back-to-back reads with req0 held, one ack every six cycles.
    c = cyc;
    start(1, 0, 0, 32'h0000_0008, 32'h0);
    push(1, 0, 0, 32'hB000_0002, c + 5);
    push(1, 0, 0, 32'hB000_000B, c + 11);
    push(1, 0, 0, 32'hB000_003C, c + 17);
    wait_ack(1);
    step();
    addr0[1] = 32'h0000_002C;
    wait_ack(1);
    step();
    addr0[1] = 32'h0000_00F0;
    wait_ack(1);
    step();
    req0[1] = 0;

    repeat (6) step();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
